// File: rtl/agu_ctx_sequencer.sv
// Context sequencer: plays a stored program of AGU config words onto outdata,
// one word per cycle, repeating it for a latched number of iterations.
module agu_ctx_sequencer #(
  parameter int WIDTH = 28,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           cfg_we,
  input  logic [AW-1:0]  cfg_addr,
  input  logic [WIDTH:0] cfg_wdata,
  input  logic [AW-1:0]  last_idx,
  input  logic [7:0]     iter_cnt,
  input  logic           start,
  input  logic           stall,
  output logic [WIDTH:0] outdata,
  output logic           valid,
  output logic [AW-1:0]  pc,
  output logic           busy,
  output logic           done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_next;

  logic [WIDTH:0] r_mem [DEPTH];
  logic [WIDTH:0] r_outdata;
  logic           r_valid;
  logic           r_done;
  logic [AW-1:0]  r_pc;
  logic [7:0]     r_it;
  logic [AW-1:0]  r_last;
  logic [7:0]     r_iter;

  logic           w_launch;
  logic           w_step;
  logic           w_wrap;
  logic           w_final;
  logic           w_fin;
  logic           w_idle;

  // Program memory is never reset so a loaded program survives RST.
  always_ff @(posedge CLK) begin
    if (cfg_we && (r_state == S_IDLE)) begin
      r_mem[cfg_addr] <= cfg_wdata;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = (iter_cnt == 8'd0) ? S_FIN : S_RUN;
        end
      end
      S_RUN: begin
        if (w_final) begin
          w_state_next = S_FIN;
        end
      end
      S_FIN:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // The iteration compare only runs in RUN, where the latched count is >= 1.
  always_comb begin
    w_idle   = (r_state == S_IDLE);
    w_fin    = (r_state == S_FIN);
    w_launch = w_idle && start;
    w_step   = (r_state == S_RUN) && !stall;
    w_wrap   = w_step && (r_pc == r_last);
    w_final  = w_wrap && (r_it == (r_iter - 8'd1));
    busy     = !w_idle;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_outdata <= '0;
      r_valid   <= 1'b0;
      r_done    <= 1'b0;
      r_pc      <= '0;
      r_it      <= 8'd0;
      r_last    <= '0;
      r_iter    <= 8'd0;
    end else begin
      r_done <= w_fin;
      if (w_idle || w_fin) begin
        r_outdata <= '0;
        r_valid   <= 1'b0;
      end
      if (w_fin) begin
        r_pc <= '0;
      end
      if (w_launch) begin
        r_last <= last_idx;
        r_iter <= iter_cnt;
        r_pc   <= '0;
        r_it   <= 8'd0;
      end
      if (w_step) begin
        r_outdata <= r_mem[r_pc];
        r_valid   <= 1'b1;
        if (w_wrap) begin
          r_pc <= '0;
          r_it <= r_it + 8'd1;
        end else begin
          r_pc <= r_pc + 1'b1;
        end
      end
    end
  end

  assign outdata = r_outdata;
  assign valid   = r_valid;
  assign pc      = r_pc;
  assign done    = r_done;

endmodule

// File: doc/agu_ctx_sequencer.md
Name: agu_ctx_sequencer

Overview:
- Per-cycle context sequencer that sits directly upstream of the AGU field decoder.
- Holds a small program of 29-bit AGU configuration words and plays them out on `outdata`, one per cycle.
- Repeats the program for a programmed number of loop iterations.
- Software/host loads words via a write port while idle, then pulses `start`; the downstream decoder slices `outdata` into op_code, ld/st bus selects, imm_val and predicate fields.

Parameters:
- WIDTH, 28, MSB index of a config word (word is WIDTH+1 bits).
- DEPTH, 16, number of context words stored.
- AW, 4, address/pc width; DEPTH = 2**AW.

Ports:
- CLK  input  1  system clock, rising-edge.
- RST  input  1  asynchronous, active-high reset.
- cfg_we  input  1  context-memory write enable.
- cfg_addr  input  AW  write address.
- cfg_wdata  input  WIDTH+1  config word to store.
- last_idx  input  AW  index of last word in program; sampled on start.
- iter_cnt  input  8  number of program iterations; sampled on start.
- start  input  1  begin playback (level sampled each edge in IDLE).
- stall  input  1  freeze playback this cycle.
- outdata  output  WIDTH+1  current config word to AGU decoder; 0 = NOP (op_code 0000).
- valid  output  1  outdata holds a program word.
- pc  output  AW  index of next word to issue.
- busy  output  1  state != IDLE.
- done  output  1  one-cycle pulse after final word retired.

Behaviour:
- Reset (async, immediate):
  - state=IDLE; outdata=0, valid=0, pc=0, busy=0, done=0; iteration counter=0; latched last/iter regs=0.
  - Context memory is NOT cleared.
- Memory:
  - Synchronous write at edge when cfg_we=1 and state==IDLE.
  - cfg_we while busy is ignored (memory unchanged).
- State machine: IDLE, RUN, FIN.
- IDLE:
  - outdata=0, valid=0, done=0.
  - On edge with start=1: latch last_idx→L and iter_cnt→N; pc<=0, it<=0.
  - If N==0: go FIN directly (no words issued). Else go RUN.
- RUN, stall=0, per edge:
  - outdata<=mem[pc]; valid<=1.
  - If pc==L: pc<=0, it<=it+1; if it==N-1 then state<=FIN.
  - Else pc<=pc+1.
- RUN, stall=1: outdata, valid, pc, it all hold (same word presented again).
- FIN, one cycle:
  - outdata<=0, valid<=0, done<=1, pc<=0; state<=IDLE.
  - done returns to 0 on the following edge.
- Latency:
  - start sampled at edge k → word 0 on outdata after edge k+1, word i after edge k+1+i (no stalls).
  - Last word of last iteration is followed by outdata=0/valid=0/done=1 after the next edge.
- Write and start together:
  - Write in IDLE at edge k together with start: write lands at edge k.
  - Read at edge k+1 sees the new data.
- start while RUN/FIN: ignored. Inputs last_idx/iter_cnt changing mid-run: ignored (latched copies used).
- Wrap: L=DEPTH-1 wraps pc from DEPTH-1 to 0 naturally; L=0 issues mem[0] every cycle for N cycles.
- Counter widths: it is 8 bits, compared against N-1 only when N≥1; N=255 runs 255 iterations with no overflow.
- Reset asserted mid-RUN: outputs drop to 0 asynchronously; after release, block is in IDLE awaiting start; memory retains program.
- stall in IDLE/FIN: no effect.
- busy is a registered-state decode: high from edge after start through the FIN cycle.

Test Plan:
- Load mem[0..2]=29'h0000_0101, 29'h0000_0202, 29'h0100_0301; L=2, N=1; start pulse at edge k → outdata 0101,0202,1000301 after edges k+1..k+3 with valid=1; edge k+4: outdata=0, valid=0, done=1; edge k+5: done=0, busy=0.
- Same program, N=3 → 9 words in order 0,1,2,0,1,2,0,1,2; pc sequence 1,2,0,… ; done exactly once after the 9th word.
- N=2, stall high for 2 cycles while word 1 is presented → word 1 held 3 cycles total, pc holds at 2; total run is 8 cycles; sequence otherwise unchanged.
- N=0 with start → no valid cycle; done=1 after edge k+1; memory write during RUN (cfg_addr=1, data=29'h1FFF_FFFF) → mem[1] unchanged on next run.
- L=0, N=4, mem[0]=29'h0000_0102 → 0102 issued 4 consecutive cycles; L=15, N=1 → all 16 words issued, pc wraps to 0.
- RST asserted during 2nd word of a run → outdata=0, valid=0, busy=0 immediately; after release, start (N=1) replays the original program from word 0.
